// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; IDLE -> BUSY (XLEN cycles) -> DONE -> IDLE.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero, zero dividend and
// signed overflow bypass BUSY and finish on the cycle after accept.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_div_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_kill,
  output logic            o_done,
  output logic            o_busy,
  output logic [XLEN-1:0] o_result
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic            op_rem, q_neg, r_neg, dz;
  logic [XLEN-1:0] dvsr, quo, rem, result;

  // Operand conditioning on the accept cycle: signed ops work on magnitudes.
  logic            is_signed, a_neg, b_neg, in_dz, early;
  logic [XLEN-1:0] mag_a, mag_b, early_res;

  assign is_signed = ~i_div_op[0];
  assign a_neg     = is_signed & i_rs1[XLEN-1];
  assign b_neg     = is_signed & i_rs2[XLEN-1];
  assign mag_a     = a_neg ? -i_rs1 : i_rs1;
  assign mag_b     = b_neg ? -i_rs2 : i_rs2;
  assign in_dz     = (i_rs2 == '0);

`ifdef DIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic in_ovf, in_az;
  assign in_ovf = is_signed & (i_rs1 == MIN_NEG) & (i_rs2 == '1);
  assign in_az  = (i_rs1 == '0);
  assign early  = in_dz | in_ovf | in_az;

  // Closed-form results for the cases that skip the iteration.
  always_comb begin
    early_res = '0;
    if (in_dz)       early_res = i_div_op[1] ? i_rs1 : '1;
    else if (in_ovf) early_res = i_div_op[1] ? '0 : i_rs1;
  end
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  // One restoring shift-subtract step: partial remainder and quotient share
  // a shift chain, the dividend bits feed in from the top of quo.
  logic [XLEN:0]   shifted, diff;
  logic            fits;
  logic [XLEN-1:0] rem_nxt, quo_nxt, q_fin, r_fin, fin_res;

  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr};
  assign fits    = ~diff[XLEN];
  assign rem_nxt = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], fits};

  // Sign fix-up on the last step; divide-by-zero quotient is all-ones
  // regardless of sign, and the remainder naturally comes out as rs1.
  assign q_fin   = dz ? '1 : (q_neg ? -quo_nxt : quo_nxt);
  assign r_fin   = r_neg ? -rem_nxt : rem_nxt;
  assign fin_res = op_rem ? r_fin : q_fin;

  // Control FSM and datapath registers; kill beats everything but reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_rem <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dz     <= 1'b0;
      dvsr   <= '0;
      quo    <= '0;
      rem    <= '0;
      result <= '0;
    end else if (i_kill) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            op_rem <= i_div_op[1];
            q_neg  <= a_neg ^ b_neg;
            r_neg  <= a_neg;
            dz     <= in_dz;
            dvsr   <= mag_b;
            quo    <= mag_a;
            rem    <= '0;
            if (early) begin
              state  <= S_DONE;
              cnt    <= '0;
              result <= early_res;
            end else begin
              state <= S_BUSY;
              cnt   <= CW'(XLEN);
            end
          end
        end
        S_BUSY: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state  <= S_DONE;
            result <= fin_res;
          end
        end
        // Same instruction still sits in EX here, so i_start is ignored.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_busy   = (state == S_BUSY);
  assign o_done   = (state == S_DONE) & ~i_kill;
  assign o_result = result;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed + randomized checks of div_unit against an
// arithmetic reference model (64-bit signed/unsigned divide).
module tb_div_unit;
  localparam int XLEN = 32;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_start, i_kill;
  logic [1:0]  i_div_op;
  logic [31:0] i_rs1, i_rs2;
  logic        o_done, o_busy;
  logic [31:0] o_result;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  div_unit #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_div_op(i_div_op),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_kill(i_kill),
    .o_done(o_done), .o_busy(o_busy), .o_result(o_result)
  );

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit eo = 1'b0;
`ifdef DIV_EARLY_OUT_EN
    eo = 1'b1;
`endif
    if (eo && (b == 32'd0 || a == 32'd0 ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return XLEN + 1;
  endfunction

  // Drives one operation and reports done latency (cycles after T0),
  // the result seen with o_done, and stray o_done pulses afterwards.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit hold, output int lat, output logic [31:0] res, output int extra);
    lat = -1; res = 'x; extra = 0;
    @(posedge i_clk); #1;
    i_start = 1'b1; i_div_op = op; i_rs1 = a; i_rs2 = b;
    for (int t = 0; t < 100; t++) begin
      @(negedge i_clk);
      if (o_done === 1'b1) begin
        lat = t; res = o_result; i_start = 1'b0;
        break;
      end
      @(posedge i_clk); #1;
      if (!hold) i_start = 1'b0;
    end
    i_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      if (o_done !== 1'b0) extra++;
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_start = 1'b0; i_kill = 1'b0;
    i_div_op = 2'b00; i_rs1 = '0; i_rs2 = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", o_done); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    total++; if (o_result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", o_result); end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp;
    bit          hold;
  } vec_t;

  task automatic test_directed;
    vec_t v[12];
    int lat, extra;
    logic [31:0] res;
    v[0]  = '{2'b00, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b1};
    v[1]  = '{2'b10, 32'd20,        32'hFFFF_FFFD, 32'h0000_0002, 1'b1};
    v[2]  = '{2'b01, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1'b1};
    v[3]  = '{2'b11, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1'b1};
    v[4]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    v[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    v[6]  = '{2'b00, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b0};
    v[7]  = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0};
    v[8]  = '{2'b00, 32'd0,         32'd5,         32'd0,         1'b1};
    v[9]  = '{2'b01, 32'd7,         32'hFFFF_FFFF, 32'd0,         1'b0};
    v[10] = '{2'b11, 32'd7,         32'hFFFF_FFFF, 32'd7,         1'b1};
    v[11] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b1};
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].hold, lat, res, extra);
      total++;
      if (res !== v[i].exp) begin
        bad++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, v[i].exp);
      end
      total++;
      if (lat != exp_lat(v[i].op, v[i].a, v[i].b)) begin
        bad++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, exp_lat(v[i].op, v[i].a, v[i].b));
      end
      total++;
      if (extra != 0) begin
        bad++; $display("FAIL directed_single_pulse[%0d]: extra pulses %0d want 0", i, extra);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a, b, res, exp;
    int lat, extra;
    bit hold;
    for (int n = 0; n < 30; n++) begin
      op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      hold = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: a = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'($urandom_range(1, 15));
        4: begin
          a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 50));
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: ;
      endcase
      exp = model(op, a, b);
      do_op(op, a, b, hold, lat, res, extra);
      total++;
      if (res !== exp) begin
        bad++; $display("FAIL random_result op=%0d a=%h b=%h: got %h want %h", op, a, b, res, exp);
      end
      total++;
      if (lat != exp_lat(op, a, b) || extra != 0) begin
        bad++; $display("FAIL random_timing op=%0d a=%h b=%h: lat %0d extra %0d want lat %0d extra 0",
                        op, a, b, lat, extra, exp_lat(op, a, b));
      end
    end
  endtask

  task automatic test_back_to_back;
    int t1 = -1, t2 = -1, pulses = 0;
    logic [31:0] r1 = 'x, r2 = 'x;
    @(posedge i_clk); #1;
    i_start = 1'b1; i_div_op = 2'b01; i_rs1 = 32'd100; i_rs2 = 32'd7;
    for (int t = 0; t < 150; t++) begin
      @(negedge i_clk);
      if (o_done === 1'b1) begin
        pulses++;
        if (t1 < 0) begin
          t1 = t; r1 = o_result; i_div_op = 2'b11;
        end else if (t2 < 0) begin
          t2 = t; r2 = o_result; i_start = 1'b0;
        end
      end
      if (t2 >= 0 && t > t2 + 4) break;
      @(posedge i_clk); #1;
    end
    i_start = 1'b0;
    total++; if (t1 != 33) begin bad++; $display("FAIL b2b_first_latency: got %0d want 33", t1); end
    total++; if (t2 - t1 != 34 || t2 < 0) begin bad++; $display("FAIL b2b_spacing: got %0d want 34", t2 - t1); end
    total++; if (r1 !== 32'd14) begin bad++; $display("FAIL b2b_divu: got %h want 0000000e", r1); end
    total++; if (r2 !== 32'd2) begin bad++; $display("FAIL b2b_remu: got %h want 00000002", r2); end
    total++; if (pulses != 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
  endtask

  task automatic test_kill;
    int lat, extra, stray;
    logic [31:0] res;
    do_op(2'b01, 32'd9, 32'd3, 1'b1, lat, res, extra);
    total++; if (res !== 32'd3) begin bad++; $display("FAIL kill_pre_result: got %h want 00000003", res); end
    @(posedge i_clk); #1;
    i_start = 1'b1; i_div_op = 2'b01; i_rs1 = 32'd50; i_rs2 = 32'd5;
    repeat (10) begin @(posedge i_clk); #1; i_start = 1'b0; end
    i_kill = 1'b1;
    @(negedge i_clk);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL kill_busy_t10: got %b want 1", o_busy); end
    @(posedge i_clk); #1;
    i_kill = 1'b0;
    @(negedge i_clk);
    total++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++; $display("FAIL kill_idle_t11: busy %b done %b want 0 0", o_busy, o_done);
    end
    total++; if (o_result !== 32'd3) begin bad++; $display("FAIL kill_result_held: got %h want 00000003", o_result); end
    stray = 0;
    repeat (40) begin @(negedge i_clk); if (o_done !== 1'b0) stray++; end
    total++; if (stray != 0) begin bad++; $display("FAIL kill_no_done: got %0d pulses want 0", stray); end
    do_op(2'b01, 32'd50, 32'd5, 1'b1, lat, res, extra);
    total++; if (res !== 32'd10 || lat != 33) begin
      bad++; $display("FAIL kill_restart: got %h lat %0d want 0000000a lat 33", res, lat);
    end
  endtask

  task automatic test_reset_mid;
    int lat, extra, stray;
    logic [31:0] res;
    @(posedge i_clk); #1;
    i_start = 1'b1; i_div_op = 2'b00; i_rs1 = 32'hFFFF_FFF9; i_rs2 = 32'd2;
    repeat (15) begin @(posedge i_clk); #1; i_start = 1'b0; end
    @(negedge i_clk);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", o_busy); end
    #2;
    i_rst_n = 1'b0;
    #1;
    total++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++; $display("FAIL rstmid_flags: busy %b done %b want 0 0", o_busy, o_done);
    end
    total++; if (o_result !== 32'd0) begin bad++; $display("FAIL rstmid_result: got %h want 0", o_result); end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    stray = 0;
    repeat (40) begin @(negedge i_clk); if (o_done !== 1'b0 || o_busy !== 1'b0) stray++; end
    total++; if (stray != 0) begin bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", stray); end
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1, lat, res, extra);
    total++; if (res !== 32'hFFFF_FFFD || lat != 33) begin
      bad++; $display("FAIL rstmid_restart: got %h lat %0d want fffffffd lat 33", res, lat);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_kill;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port i_start, input, 1: level, high while the EX-stage instruction is a divide-class op (alu_op 5'b01101).
REQ-005 SHALL have port i_div_op, input, 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled on accept.
REQ-006 SHALL have port i_rs1, input, XLEN: dividend; sampled on accept.
REQ-007 SHALL have port i_rs2, input, XLEN: divisor; sampled on accept.
REQ-008 SHALL have port i_kill, input, 1: synchronous abort of an in-flight operation.
REQ-009 SHALL have port o_done, output, 1: one-cycle pulse, result valid; consumed by the hazard unit to release the stall.
REQ-010 SHALL have port o_busy, output, 1: high in BUSY state.
REQ-011 SHALL have port o_result, output, XLEN: quotient or remainder per latched op; held until next accept.

Function
REQ-012 SHALL implement three states: IDLE, BUSY, DONE.
REQ-013 IDLE with i_start=1 and i_kill=0 SHALL accept: latch op, operand magnitudes (absolute values for DIV/REM), result signs, load iteration counter with XLEN, go to BUSY.
REQ-014 BUSY SHALL perform one restoring shift-subtract iteration per cycle and decrement the counter; after the iteration with counter==1, go to DONE.
REQ-015 DONE SHALL assert o_done for exactly one cycle, drive o_result with the final value, then go to IDLE unconditionally, ignoring i_start that cycle (same instruction still in EX).
REQ-016 Latency: first i_start cycle at T0 -> o_done at T0+XLEN+1 (T33 for XLEN=32) when not early-out.
REQ-017 A new i_start in the cycle after DONE SHALL be accepted normally (back-to-back divides).
REQ-018 Signed results: quotient negated iff operand signs differ; remainder takes dividend sign; negation in two's complement, XLEN bits, overflow discarded.
REQ-019 Divide by zero SHALL give quotient all-ones (DIV and DIVU) and remainder = i_rs1 (REM and REMU), per RV32M.
REQ-020 Signed overflow (rs1 = most negative, rs2 = -1) SHALL give DIV = rs1, REM = 0.
REQ-021 i_kill in any state SHALL force IDLE next cycle, o_done=0, o_result unchanged; i_kill has priority over i_start and DONE.
REQ-022 i_start dropping mid-BUSY SHALL NOT abort; only i_kill aborts.
REQ-023 o_busy SHALL be registered-state decode; o_done SHALL be 1 only in DONE.

Reset
REQ-024 i_rst_n low SHALL asynchronously force IDLE, counter 0, o_done 0, o_busy 0, o_result 0, all operand registers 0.
REQ-025 Reset mid-BUSY SHALL discard the operation; after release no o_done pulse for it.
REQ-026 Deassertion SHALL be synchronized externally; first accept is possible on the first edge after release.

Configuration
REQ-027 Macro DIV_EARLY_OUT_EN defined: divisor zero, dividend zero, or signed overflow SHALL skip BUSY (IDLE -> DONE), o_done at T0+1, with results per REQ-019/020.
REQ-028 Macro undefined: all operations SHALL take the full REQ-016 latency with identical result values.

Verification
REQ-029 DIV 20 / -3, start held -> o_done at T33, o_result 0xFFFFFFFA (-6); REM same -> 0x00000002.
REQ-030 DIVU 0xFFFFFFFF / 0 -> o_result 0xFFFFFFFF; REMU -> 0xFFFFFFFF; o_done at T1 with DIV_EARLY_OUT_EN, T33 without.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0x00000000; single o_done pulse.
REQ-032 Back-to-back DIVU 100/7 then REMU 100/7, i_start held across both -> two o_done pulses 34 cycles apart, results 14 then 2.
REQ-033 i_kill at T10 of DIVU 50/5 -> IDLE at T11, no o_done; restart of DIVU 50/5 -> 10.
REQ-034 i_rst_n low at T15 of DIV -7/2 -> outputs 0 immediately; after release, no o_done until a new accept.
